// File: rtl/enokida_trace_formatter.sv
// enokida_trace_formatter
// Passive monitor of the RI5CY data interface. Each granted request is timed
// from its request cycle to its response (rvalid) cycle against a free-running
// cycle counter. The result is packed into a 128-bit trace entry that is
// presented to the trace-assisted cache with a one-cycle capture strobe.
//
// Optional feature macro: ENOKIDA_TRACE_SKIP_WRITES_EN
//   When defined, store transactions are timed and queued but never emitted.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mon_data_req_i        observed data request
//   mon_data_addr_i       observed request address
//   mon_data_we_i         observed write enable
//   mon_data_be_i         observed byte enables
//   mon_data_gnt_i        observed memory grant
//   mon_data_rvalid_i     observed response valid
//   trace_enable_i        recording enable
//   trace_in              packed trace entry (holds when strobe is low)
//   trace_capture_enable  one-cycle strobe marking a new trace_in
//   lock                  sticky: TRACE_ENTRIES entries have been emitted
//   counter               free-running cycle count
//   overflow_o            sticky: grant dropped because both slots were busy
//   spurious_o            sticky: rvalid seen with nothing outstanding
module enokida_trace_formatter #(
   parameter int ADDR_WIDTH    = 16,
   parameter int DATA_WIDTH    = 32,
   parameter int TRACE_ENTRIES = 2048
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mon_data_req_i,
   input  logic [ADDR_WIDTH-1:0]   mon_data_addr_i,
   input  logic                    mon_data_we_i,
   input  logic [DATA_WIDTH/8-1:0] mon_data_be_i,
   input  logic                    mon_data_gnt_i,
   input  logic                    mon_data_rvalid_i,
   input  logic                    trace_enable_i,
   output logic [127:0]            trace_in,
   output logic                    trace_capture_enable,
   output logic                    lock,
   output logic [31:0]             counter,
   output logic                    overflow_o,
   output logic                    spurious_o
);

   localparam logic [15:0] LAST_INDEX = 16'(TRACE_ENTRIES - 1);

   typedef enum logic {IDLE, WAIT_GNT} req_state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]   addr;
      logic                    we;
      logic [DATA_WIDTH/8-1:0] be;
      logic [31:0]             req_time;
      logic                    rec;
   } pend_t;

   req_state_t  state, next_state;
   logic [31:0] req_time_q;
   logic [31:0] push_time;
   logic        grant;
   logic        push;
   logic        pop;
   logic        drop;
   logic        push_rec;

   pend_t       slots [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  occupancy;
   pend_t       head;
   logic [31:0] head_addr_ext;
   logic [15:0] entry_index;

   // Request-phase bookkeeping. A request that is granted in its first cycle
   // is timed from the live counter; one that waited uses the latched start.
   always_comb begin
      next_state = state;
      grant      = mon_data_req_i & mon_data_gnt_i;
      push_time  = (state == IDLE) ? counter : req_time_q;
      case (state)
         IDLE:     if (mon_data_req_i && !mon_data_gnt_i) next_state = WAIT_GNT;
         WAIT_GNT: if (!mon_data_req_i || mon_data_gnt_i) next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // Queue control. A same-cycle pop frees a slot for the simultaneous push,
   // so a full queue only overflows when no response arrives that cycle.
   always_comb begin
      pop      = mon_data_rvalid_i && (occupancy != 2'd0);
      push     = grant && ((occupancy != 2'd2) || pop);
      drop     = grant && (occupancy == 2'd2) && !pop;
`ifdef ENOKIDA_TRACE_SKIP_WRITES_EN
      push_rec = trace_enable_i & ~lock & ~mon_data_we_i;
`else
      push_rec = trace_enable_i & ~lock;
`endif
      head          = slots[rd_ptr];
      head_addr_ext = '0;
      head_addr_ext[ADDR_WIDTH-1:0] = head.addr;
   end

   // State register, request start latch and free-running counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_time_q <= '0;
         counter    <= '0;
      end else begin
         state   <= next_state;
         counter <= counter + 32'd1;
         if (state == IDLE && mon_data_req_i) req_time_q <= counter;
      end
   end

   // Two-slot pending FIFO of granted but not yet answered transactions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slots[0]  <= '0;
         slots[1]  <= '0;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         occupancy <= '0;
      end else begin
         if (push) begin
            slots[wr_ptr] <= '{addr: mon_data_addr_i, we: mon_data_we_i,
                               be: mon_data_be_i, req_time: push_time,
                               rec: push_rec};
            wr_ptr <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   occupancy <= occupancy + 2'd1;
            2'b01:   occupancy <= occupancy - 2'd1;
            default: occupancy <= occupancy;
         endcase
      end
   end

   // Entry emission, index/lock tracking and sticky error flags. Lock rises
   // together with the strobe of the final entry so the cache sees both at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trace_in             <= '0;
         trace_capture_enable <= 1'b0;
         entry_index          <= '0;
         lock                 <= 1'b0;
         overflow_o           <= 1'b0;
         spurious_o           <= 1'b0;
      end else begin
         trace_capture_enable <= 1'b0;
         if (pop && head.rec) begin
            trace_capture_enable <= 1'b1;
            trace_in <= {head.req_time, counter, head_addr_ext, head.we,
                         head.be, 11'b0, entry_index};
            entry_index <= entry_index + 16'd1;
            if (entry_index == LAST_INDEX) lock <= 1'b1;
         end
         if (drop) overflow_o <= 1'b1;
         if (mon_data_rvalid_i && occupancy == 2'd0) spurious_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_enokida_trace_formatter.sv
// Testbench for enokida_trace_formatter: directed scenarios with literal
// expectations, followed by randomized traffic, all checked every cycle
// against a transaction-level model of the formatter.
module tb_enokida_trace_formatter;

   localparam int TE = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req = 1'b0;
   logic [15:0]  addr = '0;
   logic         we = 1'b0;
   logic [3:0]   be = '0;
   logic         gnt = 1'b0;
   logic         rvalid = 1'b0;
   logic         en = 1'b0;
   logic [127:0] trace_in;
   logic         trace_capture_enable;
   logic         lock;
   logic [31:0]  counter;
   logic         overflow_o;
   logic         spurious_o;

   int assertCount = 0;
   int failCount = 0;

   enokida_trace_formatter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TRACE_ENTRIES(TE)) dut (
      .clk(clk), .rst_n(rst_n),
      .mon_data_req_i(req), .mon_data_addr_i(addr), .mon_data_we_i(we),
      .mon_data_be_i(be), .mon_data_gnt_i(gnt), .mon_data_rvalid_i(rvalid),
      .trace_enable_i(en),
      .trace_in(trace_in), .trace_capture_enable(trace_capture_enable),
      .lock(lock), .counter(counter), .overflow_o(overflow_o), .spurious_o(spurious_o)
   );

   always #5 clk = ~clk;

   // Transaction-level model: outstanding transactions live in a queue,
   // a pending request is just "started at cycle N".
   typedef struct {
      logic [31:0] t;
      logic [31:0] a;
      logic        w;
      logic [3:0]  b;
      logic        rec;
   } txn_t;

   txn_t         pend[$];
   txn_t         e;
   logic [31:0]  mCount = '0;
   logic [127:0] mTrace = '0;
   logic         mCap = 1'b0;
   logic         mLock = 1'b0;
   logic         mOv = 1'b0;
   logic         mSp = 1'b0;
   int           emitted = 0;
   bit           reqActive = 0;
   logic [31:0]  reqStart = '0;
   logic [31:0]  startNow;
   logic         recNow;
   bit           started = 0;

   always @(posedge clk) begin
      started = 1;
      if (!rst_n) begin
         pend.delete();
         mCount = '0; mTrace = '0; mCap = 0; mLock = 0; mOv = 0; mSp = 0;
         emitted = 0; reqActive = 0; reqStart = '0;
      end else begin
         startNow = reqActive ? reqStart : mCount;
         recNow = en & ~mLock;
`ifdef ENOKIDA_TRACE_SKIP_WRITES_EN
         if (we) recNow = 1'b0;
`endif
         mCap = 1'b0;
         if (rvalid) begin
            if (pend.size() == 0) mSp = 1'b1;
            else begin
               e = pend.pop_front();
               if (e.rec) begin
                  mTrace = {e.t, mCount, e.a, e.w, e.b, 11'b0, 16'(emitted)};
                  mCap = 1'b1;
                  if (emitted == TE - 1) mLock = 1'b1;
                  emitted++;
               end
            end
         end
         if (req && gnt) begin
            if (pend.size() < 2)
               pend.push_back('{t: startNow, a: {16'b0, addr}, w: we, b: be, rec: recNow});
            else mOv = 1'b1;
         end
         reqActive = req && !gnt;
         reqStart = startNow;
         mCount = mCount + 32'd1;
      end
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (started) begin
         checkOutput("counter", 128'(counter), 128'(mCount));
         checkOutput("capture", 128'(trace_capture_enable), 128'(mCap));
         checkOutput("trace_in", trace_in, mTrace);
         checkOutput("lock", 128'(lock), 128'(mLock));
         checkOutput("overflow", 128'(overflow_o), 128'(mOv));
         checkOutput("spurious", 128'(spurious_o), 128'(mSp));
      end
   end

   // Drives one cycle of inputs; entered and left on a falling edge.
   task automatic applyStimulus(input logic r, input logic [15:0] a, input logic w,
                                input logic [3:0] b, input logic g, input logic v);
      req = r; addr = a; we = w; be = b; gnt = g; rvalid = v;
      @(negedge clk);
   endtask

   task automatic idle();
      applyStimulus(0, 16'h0, 0, 4'h0, 0, 0);
   endtask

   task automatic waitCount(input logic [31:0] n);
      int budget = 0;
      while (mCount != n && budget < 1000) begin
         idle();
         budget++;
      end
      if (budget >= 1000) checkOutput("waitCount", 128'(mCount), 128'(n));
   endtask

   task automatic doReset();
      req = 0; gnt = 0; rvalid = 0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("asyncResetCounter", 128'(counter), 128'd0);
      checkOutput("asyncResetFlags", 128'({trace_capture_enable, lock, overflow_o, spurious_o}), 128'd0);
      checkOutput("asyncResetTrace", trace_in, 128'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
   endtask

   int strobes;

   initial begin
      en = 1'b1;
      @(negedge clk);
      doReset();

      // Single load granted immediately.
      waitCount(10);
      applyStimulus(1, 16'h1234, 0, 4'hF, 1, 0);
      waitCount(13);
      applyStimulus(0, 16'h0, 0, 4'h0, 0, 1);
      checkOutput("firstStrobe", 128'(trace_capture_enable), 128'd1);
      checkOutput("firstEntry", trace_in, {32'd10, 32'd13, 32'h1234, 1'b0, 4'hF, 11'b0, 16'd0});

      // Request waits three cycles for its grant; address taken at grant.
      waitCount(20);
      applyStimulus(1, 16'h1111, 0, 4'hF, 0, 0);
      applyStimulus(1, 16'h2222, 0, 4'hF, 0, 0);
      applyStimulus(1, 16'h2222, 0, 4'hF, 0, 0);
      applyStimulus(1, 16'hABCD, 0, 4'h3, 1, 0);
      idle();
      applyStimulus(0, 16'h0, 0, 4'h0, 0, 1);
      checkOutput("waitedEntry", trace_in, {32'd20, 32'd25, 32'hABCD, 1'b0, 4'h3, 11'b0, 16'd1});

      // Pipelined grants, then pop+push on a full queue; third emit locks.
      doReset();
      waitCount(30);
      applyStimulus(1, 16'h00A0, 0, 4'h1, 1, 0);
      applyStimulus(1, 16'h00B0, 1, 4'h2, 1, 0);
      idle();
      applyStimulus(1, 16'h00C0, 0, 4'h4, 1, 1);
      checkOutput("pipeEntry0", trace_in, {32'd30, 32'd33, 32'h00A0, 1'b0, 4'h1, 11'b0, 16'd0});
      checkOutput("pipeOverflow", 128'(overflow_o), 128'd0);
      applyStimulus(0, 16'h0, 0, 4'h0, 0, 1);
`ifndef ENOKIDA_TRACE_SKIP_WRITES_EN
      checkOutput("pipeEntry1", trace_in, {32'd31, 32'd34, 32'h00B0, 1'b1, 4'h2, 11'b0, 16'd1});
`endif
      applyStimulus(0, 16'h0, 0, 4'h0, 0, 1);
`ifndef ENOKIDA_TRACE_SKIP_WRITES_EN
      checkOutput("pipeEntry2", trace_in, {32'd33, 32'd35, 32'h00C0, 1'b0, 4'h4, 11'b0, 16'd2});
      checkOutput("pipeLock", 128'(lock), 128'd1);
`endif

      // Overflow on third grant, then a spurious response.
      doReset();
      waitCount(5);
      applyStimulus(1, 16'h0005, 0, 4'hF, 1, 0);
      applyStimulus(1, 16'h0006, 0, 4'hF, 1, 0);
      applyStimulus(1, 16'h0007, 0, 4'hF, 1, 0);
      checkOutput("overflowSet", 128'(overflow_o), 128'd1);
      applyStimulus(0, 16'h0, 0, 4'h0, 0, 1);
      applyStimulus(0, 16'h0, 0, 4'h0, 0, 1);
      checkOutput("ovSecondEntry", trace_in, {32'd6, 32'd9, 32'h0006, 1'b0, 4'hF, 11'b0, 16'd1});
      applyStimulus(0, 16'h0, 0, 4'h0, 0, 1);
      checkOutput("spuriousSet", 128'(spurious_o), 128'd1);
      checkOutput("spuriousNoStrobe", 128'(trace_capture_enable), 128'd0);

      // Five loads: only three strobes before lock freezes recording.
      doReset();
      strobes = 0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 16'(i), 0, 4'hF, 1, 0);
         applyStimulus(0, 16'h0, 0, 4'h0, 0, 1);
         if (trace_capture_enable) strobes++;
      end
      checkOutput("lockStrobes", 128'(strobes), 128'd3);
      checkOutput("lockHeld", 128'(lock), 128'd1);

`ifdef ENOKIDA_TRACE_SKIP_WRITES_EN
      doReset();
      strobes = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 16'(i), (i % 2 == 0), 4'hF, 1, 0);
         applyStimulus(0, 16'h0, 0, 4'h0, 0, 1);
         if (trace_capture_enable) strobes++;
      end
      checkOutput("skipStrobes", 128'(strobes), 128'd2);
      checkOutput("skipLastIndex", 128'(trace_in[15:0]), 128'd1);
`endif

      // Randomized traffic with occasional asynchronous resets.
      doReset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 79) == 0) doReset();
         en = ($urandom_range(0, 7) != 0);
         applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), 1'($urandom),
                       4'($urandom), 1'($urandom), $urandom_range(0, 2) == 0);
      end
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
